// File: rtl/pool_dispatch_pkg.sv
// Types shared by the dispatcher and the processor pool.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif
`ifndef ACK_TIMEOUT
`define ACK_TIMEOUT 15
`endif

package pool_dispatch_pkg;

  typedef logic [3:0] cmd_id_t;

  typedef struct packed {
    cmd_id_t    id;
    logic [3:0] opcode;
    logic [7:0] operand;
  } instr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } disp_state_t;

endpackage

// File: rtl/pool_dispatch_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  always_comb begin
    rot     = '0;
    off     = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[W'((int'(ptr) + 1 + k) % N)];
    end
    // Scan downward so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = W'(k);
        any = 1'b1;
      end
    end
    gnt_idx = W'((int'(ptr) + 1 + int'(off)) % N);
  end

endmodule

// File: rtl/pool_dispatch.sv
// Dispatches commands round-robin to idle processors, tracks ownership, fences non-acking ones.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif
`ifndef ACK_TIMEOUT
`define ACK_TIMEOUT 15
`endif

module pool_dispatch
  import pool_dispatch_pkg::*;
#(
  parameter int N_PROC      = `PROC_COUNT,
  parameter int ACK_TIMEOUT = `ACK_TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  input  instr_t                    i_cmd,
  output logic                      o_cmd_ready,
  input  logic [N_PROC-1:0]         i_busy,
  input  logic [N_PROC-1:0]         i_ack,
  input  logic [N_PROC-1:0]         i_finish,
  output instr_t [N_PROC-1:0]       o_instr,
  output logic [N_PROC-1:0]         o_valid,
  output logic [N_PROC-1:0]         o_en,
  output logic [N_PROC-1:0]         o_done,
  output logic [N_PROC-1:0]         o_fault,
  output logic                      o_idle
);
  localparam int PW = $clog2(N_PROC);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  disp_state_t       state;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     pick;
  logic              pick_any;
  logic [CW-1:0]     cnt;
  logic [N_PROC-1:0] owned;
  logic [N_PROC-1:0] elig;
  logic [N_PROC-1:0] sel_oh;
  logic [N_PROC-1:0] ack_set;
  logic [N_PROC-1:0] fault_set;
  logic              acked;
  logic              timed_out;

  assign elig = ~i_busy & ~owned & ~o_fault;

  rr_pick #(.N(N_PROC)) u_pick (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt_idx (pick),
    .any     (pick_any)
  );

  assign sel_oh    = N_PROC'(1) << sel;
  assign acked     = (state == ISSUE) && i_ack[sel];
  // Ack has priority over a timeout landing in the same cycle.
  assign timed_out = (state == ISSUE) && !i_ack[sel] && (cnt == CW'(ACK_TIMEOUT - 1));
  assign ack_set   = acked ? sel_oh : '0;
  assign fault_set = timed_out ? sel_oh : '0;

  assign o_cmd_ready = (state == IDLE) && pick_any;
  assign o_en        = owned | ((state == ISSUE) ? sel_oh : '0);
  assign o_idle      = (state == IDLE) && (owned == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      sel     <= '0;
      rr_ptr  <= PW'(N_PROC - 1);
      cnt     <= '0;
      owned   <= '0;
      o_fault <= '0;
      o_done  <= '0;
      o_valid <= '0;
      o_instr <= '0;
    end else begin
      // A finish only counts for a processor already owned before this edge.
      o_done  <= i_finish & owned;
      owned   <= (owned & ~i_finish) | ack_set;
      o_fault <= o_fault | fault_set;
      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            sel           <= pick;
            rr_ptr        <= pick;
            o_instr[pick] <= i_cmd;
            o_valid       <= N_PROC'(1) << pick;
            cnt           <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (acked || timed_out) begin
            cnt     <= '0;
            o_valid <= '0;
            state   <= IDLE;
          end else if (cnt < CW'(ACK_TIMEOUT)) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_dispatch.sv
// Directed bench for pool_dispatch with N_PROC=4, ACK_TIMEOUT=15.
module tb_pool_dispatch;
  import pool_dispatch_pkg::*;

  localparam int N  = 4;
  localparam int TO = 15;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  instr_t          cmd;
  logic            cmd_ready;
  logic [N-1:0]    busy;
  logic [N-1:0]    ack;
  logic [N-1:0]    finish;
  instr_t [N-1:0]  instr;
  logic [N-1:0]    valid;
  logic [N-1:0]    en;
  logic [N-1:0]    done;
  logic [N-1:0]    fault;
  logic            idle;

  int vec_cnt = 0;
  int err_cnt = 0;

  pool_dispatch #(.N_PROC(N), .ACK_TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .i_cmd       (cmd),
    .o_cmd_ready (cmd_ready),
    .i_busy      (busy),
    .i_ack       (ack),
    .i_finish    (finish),
    .o_instr     (instr),
    .o_valid     (valid),
    .o_en        (en),
    .o_done      (done),
    .o_fault     (fault),
    .o_idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer c at a falling edge, expect it on exp_sel, ack it after wait_n ISSUE cycles.
  task automatic dispatch(input string tag, input instr_t c, input int exp_sel,
                          input int wait_n, input logic [N-1:0] noise);
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_sel] = 1'b1;
    cmd_valid = 1'b1;
    cmd = c;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_valid"}, 32'(valid), 32'(oh));
    chk({tag, "_instr"}, 32'(instr[exp_sel]), 32'(c));
    chk({tag, "_busy_rdy"}, 32'(cmd_ready), 32'd0);
    ack = noise & ~oh;
    repeat (wait_n) @(negedge clk);
    ack = oh;
    @(negedge clk);
    ack = '0;
    chk({tag, "_vdrop"}, 32'(valid), 32'd0);
    chk({tag, "_en"}, 32'(en & oh), 32'(oh));
  endtask

  task automatic do_finish(input string tag, input logic [N-1:0] f,
                           input logic [N-1:0] exp_done, input logic [N-1:0] exp_en);
    finish = f;
    @(negedge clk);
    finish = '0;
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_en"}, 32'(en), 32'(exp_en));
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int vcycles;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    busy = '0;
    ack = '0;
    finish = '0;
    @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin order 0,1,2,3, then 0 again after it finishes.
    dispatch("rr0", 16'h1A01, 0, 1, '0);
    dispatch("rr1", 16'h2B02, 1, 1, '0);
    dispatch("rr2", 16'h3C03, 2, 1, '0);
    dispatch("rr3", 16'h4D04, 3, 1, '0);
    chk("all_owned_en", 32'(en), 32'hF);
    chk("all_owned_rdy", 32'(cmd_ready), 32'd0);
    do_finish("fin0", 4'b0001, 4'b0001, 4'b1110);
    dispatch("rr4", 16'h5E05, 0, 1, '0);
    chk("rr4_inst1_hold", 32'(instr[1]), 32'h2B02);

    // Finish on 2 first, then a mixed finish including the now non-owned 2.
    do_finish("fin2", 4'b0100, 4'b0100, 4'b1011);
    do_finish("fin1011", 4'b1111, 4'b1011, 4'b0000);
    chk("fin_idle", 32'(idle), 32'd1);

    // Skip busy: ptr=0, processor 1 busy -> 2.
    busy = 4'b0010;
    dispatch("skip", 16'h6F06, 2, 1, '0);
    busy = 4'b1111;
    #1 chk("allbusy_rdy", 32'(cmd_ready), 32'd0);
    @(negedge clk);

    // Timeout on processor 0: ptr=2, 3 busy, 2 owned -> 0.
    busy = 4'b1000;
    cmd_valid = 1'b1;
    cmd = 16'h7007;
    @(negedge clk);
    cmd_valid = 1'b0;
    busy = '0;
    vcycles = 0;
    for (int i = 0; i < 40 && valid[0]; i++) begin
      vcycles++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(vcycles), 32'(TO));
    chk("to_fault", 32'(fault), 32'b0001);
    chk("to_en", 32'(en), 32'b0100);
    do_finish("to_fin2", 4'b0100, 4'b0100, 4'b0000);
    dispatch("fenced1", 16'h8108, 1, 0, '0);
    dispatch("fenced2", 16'h9209, 2, 0, '0);
    dispatch("fenced3", 16'hA30A, 3, 0, '0);
    chk("fenced_rdy", 32'(cmd_ready), 32'd0);
    do_finish("fin_rest", 4'b1110, 4'b1110, 4'b0000);
    chk("fault_sticky", 32'(fault), 32'b0001);

    // Reset mid-ISSUE: skips faulted 0, goes to 1, then reset.
    cmd_valid = 1'b1;
    cmd = 16'hB40B;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_valid", 32'(valid), 32'b0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_en", 32'(en), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_idle", 32'(idle), 32'd1);

    // Ack on the last allowed ISSUE cycle, with stray acks from others meanwhile.
    dispatch("ack_limit", 16'hC50C, 0, TO - 1, 4'b1110);
    chk("ack_limit_fault", 32'(fault), 32'd0);
    chk("ack_limit_en", 32'(en), 32'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pool_dispatch.md
# pool_dispatch

Dispatcher that sits between the command front-end and the processor pool. It accepts one instruction at a time over a valid/ready handshake and picks an idle processor round-robin. It presents the instruction to that processor until the processor acknowledges it, then tracks ownership until the processor reports finish. Processors that fail to acknowledge within a bounded time are fenced off and flagged.

## Interface
- `N_PROC`, default `` `PROC_COUNT `` (4): number of processors; must be ≥ 2.
- `ACK_TIMEOUT`, default 15: maximum number of cycles in ISSUE without an ack before a fault is declared.
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_cmd_valid` in 1: a command is offered.
- `i_cmd` in `instr_t`: the offered instruction.
- `o_cmd_ready` out 1: the dispatcher accepts the command this cycle.
- `i_busy` in [N_PROC-1:0]: pool `o_busy`.
- `i_ack` in [N_PROC-1:0]: pool `o_ack`.
- `i_finish` in [N_PROC-1:0]: pool `o_finish`.
- `o_instr` out `instr_t` [N_PROC-1:0]: per-processor instruction, to pool `i_instr`.
- `o_valid` out [N_PROC-1:0]: instruction present, to pool `i_valid`.
- `o_en` out [N_PROC-1:0]: processor owned/enabled, to pool `i_en`.
- `o_done` out [N_PROC-1:0]: one-cycle pulse per processor that completed.
- `o_fault` out [N_PROC-1:0]: sticky; the processor missed its ack timeout.
- `o_idle` out 1: state is IDLE and no processor is owned.

## Operation
- **Eligibility:** `elig[i] = ~i_busy[i] & ~owned[i] & ~o_fault[i]`.
- **FSM state IDLE:**
  - `o_cmd_ready = |elig`.
  - On `i_cmd_valid & o_cmd_ready`:
    - latch `i_cmd`;
    - pick `sel` = first eligible index searching from `rr_ptr+1` upward, wrapping;
    - set `rr_ptr <= sel`;
    - go to ISSUE.
- **FSM state ISSUE:**
  - `o_valid[sel]=1`, `o_instr[sel]` = latched command, `o_cmd_ready=0`.
  - The timeout counter increments each ISSUE cycle.
  - If `i_ack[sel]` is sampled high: set `owned[sel]`, clear the counter, go to IDLE.
  - Otherwise, if the counter reaches ACK_TIMEOUT−1 with no ack: set `o_fault[sel]`, clear the counter, go to IDLE. The command is dropped.
- **Outputs from ownership:** `o_en = owned | (ISSUE ? onehot(sel) : 0)`.
- **Non-selected lines:** `o_instr[i]` for non-selected processors holds its last driven value and is never written except on dispatch.
- **Finish:** `i_finish[i] & owned[i]` clears `owned[i]` and pulses `o_done[i]` on the next cycle. Multiple finishes in one cycle are all handled.
- **Ignored events:**
  - A finish from a non-owned processor.
  - An ack from any processor other than `sel`, or outside ISSUE.
- **Widths:**
  - `rr_ptr`, `sel`: `$clog2(N_PROC)` bits.
  - Counter: `$clog2(ACK_TIMEOUT+1)` bits, saturating; it never wraps.
- **All faulted or busy:** `o_cmd_ready` stays low indefinitely. No deadlock is reported. Only reset clears `o_fault`.

## Timing
- **Reset values:**
  - state = IDLE; `owned`, `o_fault`, `o_done`, `o_valid`, `o_en` = 0.
  - `o_instr` = all zeros; `rr_ptr = N_PROC-1`, so the first pick is processor 0.
  - `o_idle = 1`; `o_cmd_ready` is combinational from `elig`.
- **Dispatch sequence:**
  - Accept in cycle T.
  - `o_valid[sel]` and `o_en[sel]` high from T+1.
  - An ack seen in T+k drops `o_valid` at T+k+1.
  - The next accept is possible at T+k+1.
  - Minimum spacing between accepts is 2 cycles.
- **Timeout:** with no ack, `o_valid` is high for exactly ACK_TIMEOUT cycles; `o_fault[sel]` rises on the following edge.
- **Simultaneous events:**
  - Ack and timeout in the same cycle: ack wins and no fault is set.
  - Finish in the same cycle as ack for the same index: ack wins and `owned` is set. The finish is ignored because the processor was not yet owned.
- **`o_done`:** registered, one cycle after `i_finish`.
- **Reset mid-ISSUE:** `o_valid`/`o_en` drop asynchronously; the command is lost.

## Structure
- **Shared package with `instr_t`/`cmd_id_t`:** add `disp_state_t` enum (IDLE, ISSUE).
- **Defines:** `ACK_TIMEOUT` default goes alongside `PROC_COUNT`.
- **Sub-module `rr_pick`:** combinational, parameter `N`, inputs `req[N]` and `ptr`, outputs `gnt_idx` and `any`. It does the rotate, priority-encode and unrotate. It is reusable for a later memory-port arbiter.
- **Top:** `pool_dispatch` instantiates one `rr_pick`. It is wired to `pool` by name, one bit/element per processor.

## Test plan
- **Round-robin order:** reset, all idle, 4 back-to-back commands each acked 1 cycle after `o_valid` → dispatched to processors 0, 1, 2, 3 in order; 5th command goes to 0 once 0 finishes.
- **Skip busy:** `i_busy = 4'b0010`, `rr_ptr = 0` → next command goes to processor 2; `o_cmd_ready = 0` when `i_busy = 4'b1111`.
- **Timeout:** processor 0 never acks, ACK_TIMEOUT=15 → `o_valid[0]` high for exactly 15 cycles, then `o_fault[0] = 1`. Subsequent commands never select 0 until reset.
- **Ack at limit:** ack on the 15th ISSUE cycle → no fault, `owned[0] = 1`.
- **Concurrent finish:** `i_finish = 4'b1011` with processors 0, 1, 3 owned → `o_done = 4'b1011` for one cycle, `owned` cleared. A finish on non-owned processor 2 gives no `o_done`.
- **Reset mid-ISSUE:** assert `i_rst` during ISSUE → same cycle `o_valid = 0` and `o_en = 0`; after release the first pick is processor 0.
